mux16_rr_sched: RTL and testbench
=================================

Name: mux16_rr_sched

Overview:
Round-robin scheduler that shares one 16:1 mux output between 16 requesters. Drives the mux select and a one-hot grant vector. Supports per-grant hold with a release handshake and a hold-time limit so no requester can starve the others. Sits directly in front of the 16:1 mux select input in the combinational-circuit datapath.

Parameters:
N, 16, number of requesters and mux inputs; fixed at 16 for this revision.
SELW, 4, select width; log2(N).
MAX_HOLD, 8, maximum cycles one grant may be held before forced rotation; legal range 2..256.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  16  request vector; bit i means requester i wants the mux.
done  input  1  current owner releases the mux; sampled only while valid=1.
sel  output  4  registered mux select, driven to the 16:1 mux select input.
grant  output  16  registered one-hot grant; equals 1<<sel while valid=1, else 0.
valid  output  1  a grant is active and sel is meaningful.
timeout  output  1  one-cycle pulse when a grant is force-released by the hold limit.

Behaviour:
- Reset (async, immediate): state=IDLE, sel=0, grant=0, valid=0, timeout=0, ptr=0, hold_cnt=0. Asserting reset during a grant drops grant/valid at once; there is no completion of the current hold.
- ptr (4-bit, internal) is the search start. Winner = first set bit of req at index ptr, ptr+1, ... mod 16.
- States: IDLE, GRANT.
- IDLE: if req != 0 at edge k, load sel=winner, grant=1<<winner, valid=1, hold_cnt=0, next state GRANT. Outputs are visible in cycle k+1, so latency is 1 clock. If req == 0, remain in IDLE. done is ignored in IDLE.
- GRANT, each edge:
  - Release conditions: done=1; or req[sel]=0; or hold_cnt==MAX_HOLD-1.
  - No release: hold_cnt increments; outputs unchanged.
  - Release: ptr=sel+1 with wrap 15->0. Search req, including the current owner, from the new ptr.
  - Release with a winner: new sel/grant loaded on the same edge (back-to-back, no idle cycle), hold_cnt=0, stay in GRANT.
  - Release with no winner: valid=0, grant=0, sel holds its last value, go to IDLE.
- timeout=1 for exactly the one cycle after a release caused only by the hold limit. If done=1 or req[sel]=0 coincides with the limit, it is a normal release and timeout stays 0.
- The current owner is searched last after a release, so a sole requester that times out is re-granted immediately with hold_cnt=0 and a timeout pulse.
- grant is always one-hot or zero. sel never changes while valid=1 except at a release edge.
- hold_cnt width is ceil(log2(MAX_HOLD)). It never wraps, because the release at MAX_HOLD-1 always clears it.
- Requests arriving or dropping for non-owners during a grant have no effect until the next release.

Test Plan:
1. Reset, then req=16'h0024 → 1 clock later sel=2, grant=16'h0004, valid=1. Pulse done → next cycle sel=5, grant=16'h0020. Drop req[5] → valid=0, grant=0, sel stays 5.
2. Wrap-around: get sel=15 granted, then req=16'h8001 and pulse done → sel=0, grant=16'h0001. After done again → sel=15.
3. Hold limit: req=16'h0240 held, no done → sel=6 for exactly 8 cycles, timeout=1 for one cycle as sel=9 takes over, and timeout=0 before and after.
4. Sole-requester timeout: req=16'h0008 held, no done → sel=3 held continuously with valid=1, timeout pulses every 8 cycles, grant never drops.
5. Simultaneous: done=1 on the 8th hold cycle with req=16'h0240 → rotation to sel=9 with timeout=0. Separately, done while IDLE → no output change.
6. Async reset mid-grant: assert rst between clock edges while sel=5 → grant=0, valid=0, sel=0 without waiting for a clock. After deassert with req=16'h0020 → sel=5 is re-granted 1 clock later, since ptr was reset to 0.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 mux select with a grant hold, release handshake and hold-time limit.
// Grant is visible 1 clock after a request; back-to-back handover on release, no idle gap when others wait.
module mux16_rr_sched #(
  parameter int N        = 16,
  parameter int SELW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    grant,
  output logic            valid,
  output logic            timeout
);

  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t          r_state, w_nxt_state;
  logic [SELW-1:0] r_sel, w_nxt_sel;
  logic [N-1:0]    r_grant, w_nxt_grant;
  logic            r_valid, w_nxt_valid;
  logic            r_timeout, w_nxt_timeout;
  logic [SELW-1:0] r_ptr, w_nxt_ptr;
  logic [HW-1:0]   r_hold, w_nxt_hold;

  logic [SELW-1:0] w_start;
  logic [SELW-1:0] w_win;
  logic            w_found;
  logic            w_hold_lim;
  logic            w_release;

  // On a release the search restarts just past the owner, so the owner is considered last.
  assign w_start = (r_state == S_GRANT) ? r_sel + SELW'(1) : r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[w_start + SELW'(i)]) begin
        w_found = 1'b1;
        w_win   = w_start + SELW'(i);
      end
    end
  end

  assign w_hold_lim = (r_hold == HW'(MAX_HOLD - 1));
  assign w_release  = done || !req[r_sel] || w_hold_lim;

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_sel     = r_sel;
    w_nxt_grant   = r_grant;
    w_nxt_valid   = r_valid;
    w_nxt_timeout = 1'b0;
    w_nxt_ptr     = r_ptr;
    w_nxt_hold    = r_hold;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_state = S_GRANT;
          w_nxt_sel   = w_win;
          w_nxt_grant = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_nxt_valid = 1'b1;
          w_nxt_hold  = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_nxt_ptr     = r_sel + SELW'(1);
          // Only a pure hold-limit release counts as a timeout.
          w_nxt_timeout = w_hold_lim && !done && req[r_sel];
          w_nxt_hold    = '0;
          if (w_found) begin
            w_nxt_sel   = w_win;
            w_nxt_grant = {{(N-1){1'b0}}, 1'b1} << w_win;
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_grant = '0;
            w_nxt_valid = 1'b0;
          end
        end else begin
          w_nxt_hold = r_hold + HW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sel     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_sel     <= w_nxt_sel;
      r_grant   <= w_nxt_grant;
      r_valid   <= w_nxt_valid;
      r_timeout <= w_nxt_timeout;
      r_ptr     <= w_nxt_ptr;
      r_hold    <= w_nxt_hold;
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed and randomized checks of mux16_rr_sched against a queue-free round-robin reference model.
module tb_mux16_rr_sched;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] req = '0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;

  int errs   = 0;
  int checks = 0;

  // reference model: owner, how many cycles its grant has been visible, search start
  bit m_valid;
  int m_sel;
  int m_ptr;
  int m_age;
  bit m_timeout;

  mux16_rr_sched #(.N(16), .SELW(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant(grant), .valid(valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int winner(input logic [15:0] r, input int start);
    for (int k = 0; k < 16; k++)
      if (r[(start + k) % 16]) return (start + k) % 16;
    return -1;
  endfunction

  task automatic m_reset();
    m_valid = 0; m_sel = 0; m_ptr = 0; m_age = 0; m_timeout = 0;
  endtask

  task automatic m_step(input logic [15:0] r, input logic d);
    int w;
    bit lim, rel;
    if (!m_valid) begin
      m_timeout = 0;
      w = winner(r, m_ptr);
      if (w >= 0) begin m_valid = 1; m_sel = w; m_age = 1; end
    end else begin
      lim = (m_age == MAX_HOLD);
      rel = d || !r[m_sel] || lim;
      if (rel) begin
        m_timeout = lim && !d && r[m_sel];
        m_ptr = (m_sel + 1) % 16;
        w = winner(r, m_ptr);
        if (w >= 0) begin m_sel = w; m_age = 1; end
        else m_valid = 0;
      end else begin
        m_timeout = 0;
        m_age++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_valid"},   {31'd0, valid},   {31'd0, m_valid});
    chk({tag, "_sel"},     {28'd0, sel},     m_sel);
    chk({tag, "_grant"},   {16'd0, grant},   m_valid ? (32'd1 << m_sel) : 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, {31'd0, m_timeout});
  endtask

  // called at a negedge: drive, clock, update model, check at the next negedge
  task automatic cycle(input string tag, input logic [15:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    m_step(r, d);
    @(negedge clk);
    chk_model(tag);
  endtask

  initial begin
    logic [15:0] rr;
    logic        dd;

    m_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_grant", {16'd0, grant}, 32'd0);
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // basic grant, done handover, drop to idle
    cycle("t1_grant", 16'h0024, 1'b0);
    chk("t1_sel2", {28'd0, sel}, 32'd2);
    cycle("t1_done", 16'h0024, 1'b1);
    chk("t1_sel5", {28'd0, sel}, 32'd5);
    chk("t1_grant5", {16'd0, grant}, 32'h0020);
    cycle("t1_drop", 16'h0000, 1'b0);
    chk("t1_idle_sel", {28'd0, sel}, 32'd5);
    chk("t1_idle_valid", {31'd0, valid}, 32'd0);

    // wrap-around 15 -> 0 -> 15
    cycle("t2_g15", 16'h8000, 1'b0);
    chk("t2_sel15", {28'd0, sel}, 32'd15);
    cycle("t2_wrap", 16'h8001, 1'b1);
    chk("t2_sel0", {16'd0, grant}, 32'h0001);
    cycle("t2_back", 16'h8001, 1'b1);
    chk("t2_sel15b", {28'd0, sel}, 32'd15);
    cycle("t2_idle", 16'h0000, 1'b0);

    // hold limit forces rotation 6 -> 9 with a single timeout pulse
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle("t3_hold", 16'h0240, 1'b0);
      chk("t3_sel6", {28'd0, sel}, 32'd6);
      chk("t3_no_to", {31'd0, timeout}, 32'd0);
    end
    cycle("t3_rot", 16'h0240, 1'b0);
    chk("t3_sel9", {28'd0, sel}, 32'd9);
    chk("t3_to", {31'd0, timeout}, 32'd1);
    cycle("t3_after", 16'h0240, 1'b0);
    chk("t3_to_clr", {31'd0, timeout}, 32'd0);
    cycle("t3_idle", 16'h0000, 1'b0);

    // sole requester re-granted at each timeout without dropping
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      cycle("t4_sole", 16'h0008, 1'b0);
      chk("t4_valid", {31'd0, valid}, 32'd1);
      chk("t4_grant", {16'd0, grant}, 32'h0008);
      chk("t4_to", {31'd0, timeout}, (i % MAX_HOLD == 0 && i > 0) ? 32'd1 : 32'd0);
    end
    cycle("t4_idle", 16'h0000, 1'b0);

    // done coincides with the limit: normal release, no timeout
    for (int i = 0; i < MAX_HOLD; i++) cycle("t5_hold", 16'h0240, 1'b0);
    chk("t5_sel6", {28'd0, sel}, 32'd6);
    cycle("t5_done", 16'h0240, 1'b1);
    chk("t5_sel9", {28'd0, sel}, 32'd9);
    chk("t5_no_to", {31'd0, timeout}, 32'd0);
    cycle("t5_idle", 16'h0000, 1'b0);
    cycle("t5_idle_done", 16'h0000, 1'b1);
    chk("t5_idle_sel", {28'd0, sel}, 32'd9);
    chk("t5_idle_valid", {31'd0, valid}, 32'd0);

    // asynchronous reset between edges while sel=5
    cycle("t6_grant", 16'h0020, 1'b0);
    chk("t6_sel5", {28'd0, sel}, 32'd5);
    #2 rst = 1'b1;
    #1;
    m_reset();
    chk("t6_arst_grant", {16'd0, grant}, 32'd0);
    chk("t6_arst_valid", {31'd0, valid}, 32'd0);
    chk("t6_arst_sel", {28'd0, sel}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle("t6_regrant", 16'h0020, 1'b0);
    chk("t6_sel5b", {28'd0, sel}, 32'd5);

    // random traffic with sticky requests so the hold limit is exercised
    rr = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: rr = 16'h0000;
          1: rr = 16'd1 << $urandom_range(0, 15);
          default: rr = 16'($urandom) & 16'($urandom);
        endcase
      end
      dd = ($urandom_range(0, 3) == 0);
      cycle("rnd", rr, dd);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
